// File: rtl/de_pipe_reg.sv
// rtl/de_pipe_reg.sv - decode/execute stage register with two-entry skid buffer, flush and stall counter
module de_pipe_reg #(
    parameter int              OP_W   = 6,
    parameter int              DATA_W = 160,
    parameter logic [OP_W-1:0] NOP_OP = 6'b110111,
    parameter int              CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [OP_W-1:0]     main_op_q, main_op_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [OP_W-1:0]     skid_op_q, skid_op_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                accept;
    logic                drain;

    // Handshake flags come from registered state only, so in_ready never sees out_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_op_d   = main_op_q;
        main_data_d = main_data_q;
        skid_op_d   = skid_op_q;
        skid_data_d = skid_data_q;
        stall_d     = stall_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = ONE;
                    main_op_d   = in_op;
                    main_data_d = in_data;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_op_d   = in_op;
                    main_data_d = in_data;
                end else if (accept) begin
                    state_d     = FULL;
                    skid_op_d   = in_op;
                    skid_data_d = in_data;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d     = ONE;
                    main_op_d   = skid_op_q;
                    main_data_d = skid_data_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (flush) begin
            state_d = EMPTY;
        end

        // Counts stalled cycles regardless of flush; sticks at all-ones.
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstd) begin
            state_q <= EMPTY;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    // Payload flops need no reset: they are only observed through the out_valid gate.
    always_ff @(posedge clk) begin
        main_op_q   <= main_op_d;
        main_data_q <= main_data_d;
        skid_op_q   <= skid_op_d;
        skid_data_q <= skid_data_d;
    end

    assign out_op    = out_valid ? main_op_q : NOP_OP;
    assign out_data  = out_valid ? main_data_q : '0;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

endmodule

// File: doc/de_pipe_reg.md
# de_pipe_reg

Parametrised, flow-controlled pipeline stage register for the decode→execute boundary. It is the next-generation replacement for the fixed-field stage register and adds the following:
- a generic payload width and a configurable NOP opcode;
- valid/ready handshaking with a two-entry skid buffer, so a stall propagates upstream from registered state only;
- a flush input that squashes in-flight entries into bubbles;
- a saturating stall-cycle counter for performance analysis.

## Interface
- OP_W, 6, opcode field width
- DATA_W, 160, width of the remaining packed payload (pc, regs, immediates, operands)
- NOP_OP, 6'b110111, opcode presented on the output whenever no valid entry is held
- CNT_W, 16, width of the stall counter

- clk  in  1  clock; all state updates on rising edge
- rstd  in  1  reset; **synchronous, active-high**
- flush  in  1  squash all held entries (branch/jump redirect)
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry this cycle
- in_op  in  OP_W  upstream opcode
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts the head entry this cycle
- out_op  out  OP_W  head opcode; NOP_OP when out_valid=0
- out_data  out  DATA_W  head payload; all-zero when out_valid=0
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating

## Operation
- Storage: main register (head) plus skid register. Entries leave in arrival order.
- State is held as occupancy. EMPTY=0, ONE=1 (main only), FULL=2 (main+skid).
- Accept event: in_valid & in_ready. Drain event: out_valid & out_ready.
- in_ready is 1 in EMPTY and ONE, and 0 in FULL. It is a function of the registered state only, with no combinational path from out_ready.
- out_valid is 1 in ONE and FULL.
- Transitions when flush=0:
  - EMPTY: accept → ONE (entry to main).
  - ONE: accept & drain → ONE (new entry to main). Accept only → FULL (new entry to skid). Drain only → EMPTY.
  - FULL: drain → ONE (skid moves to main). No drain → FULL, with both entries held.
  - No accept is possible in FULL.
- flush=1 (overrides everything):
  - The next state is EMPTY.
  - An entry offered in the same cycle is discarded, even though in_ready may read 1.
  - The drain flag in the flush cycle is still visible to downstream. Downstream owns whether to ignore it.
- Output gating: out_op = NOP_OP and out_data = 0 whenever out_valid=0. An empty stage therefore always presents a bubble.
- stall_cnt:
  - Increments by 1 each cycle out_valid & ~out_ready.
  - Saturates at 2^CNT_W−1, with no wrap.
  - Unaffected by flush. Cleared only by rstd.
- Illegal inputs: the block ignores in_op/in_data when accept is 0, so X is allowed there.

## Timing
- Reset (rstd=1 at an edge) gives the following values after that edge:
  - occupancy=0, out_valid=0, in_ready=1;
  - out_op=NOP_OP, out_data=0, stall_cnt=0.
- Reset mid-operation discards all entries, with the same result as flush, and also clears stall_cnt.
- Latency: an entry accepted at edge N into an empty stage is on out_* from N to N+1 (1 cycle).
- Throughput: 1 entry/cycle sustained while out_ready=1, with no bubbles.
- Backpressure:
  - out_ready dropping with 1 entry held absorbs one more entry.
  - in_ready falls on the following edge.
  - Upstream must hold in_valid/in_op/in_data stable while in_valid & ~in_ready.
- Recovery: in FULL, the first out_ready=1 cycle drains the head. in_ready returns to 1 the next cycle, and the skid entry presents at the next edge.
- Flush: out_valid=0 and in_ready=1 from the edge after flush. A new entry can be accepted in the cycle right after flush.

## Test plan
- Reset: hold rstd=1 for 2 cycles with in_valid=1 → out_valid=0, out_op=6'b110111, out_data=0, occupancy=0, stall_cnt=0, in_ready=1.
- Streaming: out_ready=1, push ops 1..8 back-to-back → ops 1..8 appear in order, one per cycle, 1-cycle latency, in_ready stays 1, stall_cnt=0.
- Backpressure/skid: push 1,2,3 with out_ready=0 from cycle 1.
  - Op 2 lands in skid, occupancy=2, in_ready=0; op 3 is held upstream.
  - After 5 stall cycles stall_cnt=5. Release gives output 1,2,3 in order.
- Flush at FULL: occupancy=2 (ops 4,5), assert flush with in_valid=1 op 6 → next cycle occupancy=0, out_op=NOP_OP; op 6 is never emitted.
- Saturation: CNT_W=4, hold a valid head with out_ready=0 for 20 cycles → stall_cnt reaches 15 and stays there. A flush leaves it at 15; rstd clears it to 0.
- Random: random in_valid/out_ready/flush for 10k cycles checked against a 2-deep reference queue. Also check that in_ready never depends on the same-cycle out_ready.
